edge_detect_multi: RTL and testbench

Parametrised multi-channel edge detector: the next generation of the single-channel level-to-tick detectors. Each of CH asynchronous level inputs passes through a synchroniser and an optional debounce filter. A per-channel mode selects rising, falling, both or no edges. Each channel produces a one-cycle tick, a sticky pending flag and a saturating event counter, and an OR-reduced interrupt is provided. It sits between raw pushbutton/sensor pins and the control FSMs and interrupt logic.

---
 rtl/edge_detect_multi.sv | 96 +++++++++
 tb/tb_edge_detect_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel level-to-tick detector: per-channel synchroniser, debounce filter,
// mode-qualified one-cycle tick, sticky flag, saturating event counter and OR'd irq.
module edge_detect_multi #(
  parameter int CH    = 4,
  parameter int SYNC  = 2,
  parameter int DB_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH-1:0]      level,
  input  logic [2*CH-1:0]    mode,
  input  logic [DB_W-1:0]    db_limit,
  input  logic [CH-1:0]      clr,
  output logic [CH-1:0]      tick,
  output logic [CH-1:0]      flag,
  output logic [CH*CNT_W-1:0] count,
  output logic               irq
);

  logic [SYNC-1:0]  syncQ   [CH];
  logic [CH-1:0]    syncLast;
  logic [CH-1:0]    fQ, fD;
  logic [DB_W-1:0]  cQ      [CH];
  logic [DB_W-1:0]  cD      [CH];
  logic [CH-1:0]    tickQ, tickD;
  logic [CH-1:0]    flagQ, flagD;
  logic [CNT_W-1:0] countQ  [CH];
  logic [CNT_W-1:0] countD  [CH];

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      syncLast[i] = syncQ[i][SYNC-1];
    end
  end

  // f follows s in every mode so that enabling a channel later never fires a stale edge;
  // mode only gates whether the filtered edge becomes a tick.
  always_comb begin
    fD    = fQ;
    tickD = '0;
    flagD = flagQ;
    for (int i = 0; i < CH; i++) begin
      cD[i]     = cQ[i];
      countD[i] = countQ[i];
      if (syncLast[i] == fQ[i]) begin
        cD[i] = '0;
      end else if (cQ[i] >= db_limit) begin
        fD[i]    = syncLast[i];
        cD[i]    = '0;
        tickD[i] = syncLast[i] ? mode[2*i] : mode[2*i+1];
      end else begin
        cD[i] = cQ[i] + DB_W'(1);
      end

      // A tick coinciding with clr wins: flag stays set and the count restarts at 1.
      flagD[i] = tickD[i] | (flagQ[i] & ~clr[i]);
      if (clr[i]) begin
        countD[i] = CNT_W'(tickD[i]);
      end else if (tickD[i] && (countQ[i] != {CNT_W{1'b1}})) begin
        countD[i] = countQ[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fQ    <= '0;
      tickQ <= '0;
      flagQ <= '0;
      for (int i = 0; i < CH; i++) begin
        syncQ[i]  <= '0;
        cQ[i]     <= '0;
        countQ[i] <= '0;
      end
    end else begin
      fQ    <= fD;
      tickQ <= tickD;
      flagQ <= flagD;
      for (int i = 0; i < CH; i++) begin
        syncQ[i]  <= {syncQ[i][SYNC-2:0], level[i]};
        cQ[i]     <= cD[i];
        countQ[i] <= countD[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : gCount
    assign count[g*CNT_W +: CNT_W] = countQ[g];
  end

  assign tick = tickQ;
  assign flag = flagQ;
  assign irq  = |flagQ;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed self-checking bench for edge_detect_multi (CH=4, SYNC=2, DB_W=4, CNT_W=8).
module tb_edge_detect_multi;

  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int DB_W  = 4;
  localparam int CNT_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [CH-1:0]       level;
  logic [2*CH-1:0]     mode;
  logic [DB_W-1:0]     dbLimit;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       tick;
  logic [CH-1:0]       flag;
  logic [CH*CNT_W-1:0] count;
  logic                irq;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  edge_detect_multi #(.CH(CH), .SYNC(SYNC), .DB_W(DB_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .db_limit(dbLimit),
    .clr(clr), .tick(tick), .flag(flag), .count(count), .irq(irq)
  );

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; level = '0; mode = '0; dbLimit = '0; clr = '0;
    repeat (3) stepClock();
    nChecks++; if (tick !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_tick got=%b exp=%b", tick, 4'b0000); end
    nChecks++; if (flag !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_flag got=%b exp=%b", flag, 4'b0000); end
    nChecks++; if (count !== 32'h0) begin nFails++; $display("[TB] FAIL reset_count got=%h exp=%h", count, 32'h0); end
    nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_irq got=%b exp=%b", irq, 1'b0); end
    reset = 1'b0;
    repeat (2) stepClock();
    nChecks++; if (tick !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_idle_tick got=%b exp=%b", tick, 4'b0000); end
  endtask

  task automatic test_latency();
    logic [CH-1:0] seen;
    mode = 8'b0000_0001; dbLimit = 4'd0; level = 4'b0001;
    repeat (2) stepClock();
    nChecks++; if (tick !== 4'b0000) begin nFails++; $display("[TB] FAIL lat_early got=%b exp=%b", tick, 4'b0000); end
    stepClock();
    nChecks++; if (tick !== 4'b0001) begin nFails++; $display("[TB] FAIL lat_tick got=%b exp=%b", tick, 4'b0001); end
    nChecks++; if (flag !== 4'b0001) begin nFails++; $display("[TB] FAIL lat_flag got=%b exp=%b", flag, 4'b0001); end
    nChecks++; if (cnt(0) !== 8'd1) begin nFails++; $display("[TB] FAIL lat_count got=%0d exp=%0d", cnt(0), 1); end
    nChecks++; if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL lat_irq got=%b exp=%b", irq, 1'b1); end
    stepClock();
    nChecks++; if (tick !== 4'b0000) begin nFails++; $display("[TB] FAIL lat_oneshot got=%b exp=%b", tick, 4'b0000); end
    nChecks++; if (flag !== 4'b0001) begin nFails++; $display("[TB] FAIL lat_sticky got=%b exp=%b", flag, 4'b0001); end
    level = 4'b0000; seen = '0;
    repeat (6) begin stepClock(); seen |= tick; end
    nChecks++; if (seen !== 4'b0000) begin nFails++; $display("[TB] FAIL lat_nofall got=%b exp=%b", seen, 4'b0000); end
    clr = 4'b0001; stepClock(); clr = 4'b0000;
    nChecks++; if (flag !== 4'b0000) begin nFails++; $display("[TB] FAIL lat_clr_flag got=%b exp=%b", flag, 4'b0000); end
    nChecks++; if (cnt(0) !== 8'd0) begin nFails++; $display("[TB] FAIL lat_clr_count got=%0d exp=%0d", cnt(0), 0); end
    nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL lat_clr_irq got=%b exp=%b", irq, 1'b0); end
  endtask

  task automatic test_debounce();
    logic [31:0] map;
    mode = 8'b0000_1100; dbLimit = 4'd3;
    level = 4'b0010; map = '0;
    for (int i = 1; i <= 14; i++) begin
      stepClock();
      if (i == 3) level = 4'b0000;
      map[i] = tick[1];
    end
    nChecks++; if (map !== 32'h0) begin nFails++; $display("[TB] FAIL db_glitch got=%h exp=%h", map, 32'h0); end
    level = 4'b0010; map = '0;
    for (int i = 1; i <= 14; i++) begin
      stepClock();
      if (i == 4) level = 4'b0000;
      map[i] = tick[1];
    end
    nChecks++; if (map !== 32'h0000_0440) begin nFails++; $display("[TB] FAIL db_pulse_ticks got=%h exp=%h", map, 32'h0000_0440); end
    nChecks++; if (cnt(1) !== 8'd2) begin nFails++; $display("[TB] FAIL db_count got=%0d exp=%0d", cnt(1), 2); end
    nChecks++; if (flag[1] !== 1'b1) begin nFails++; $display("[TB] FAIL db_flag got=%b exp=%b", flag[1], 1'b1); end
  endtask

  task automatic test_falling_and_off();
    logic [31:0] map;
    mode = 8'b0010_0000; dbLimit = 4'd0;
    level = 4'b0100; map = '0;
    for (int i = 1; i <= 12; i++) begin
      stepClock();
      if (i == 6) level = 4'b0000;
      map[i] = tick[2];
    end
    nChecks++; if (map !== 32'h0000_0200) begin nFails++; $display("[TB] FAIL fall_only got=%h exp=%h", map, 32'h0000_0200); end
    nChecks++; if (cnt(2) !== 8'd1) begin nFails++; $display("[TB] FAIL fall_count got=%0d exp=%0d", cnt(2), 1); end
    mode = 8'b0000_0000; level = 4'b0100; map = '0;
    for (int i = 1; i <= 12; i++) begin
      stepClock();
      if (i == 6) level = 4'b0000;
      map[i] = tick[2];
    end
    nChecks++; if (map !== 32'h0) begin nFails++; $display("[TB] FAIL off_ticks got=%h exp=%h", map, 32'h0); end
    nChecks++; if (cnt(2) !== 8'd1) begin nFails++; $display("[TB] FAIL off_count got=%0d exp=%0d", cnt(2), 1); end
    level = 4'b0100;
    repeat (6) stepClock();
    mode = 8'b0011_0000; map = '0;
    for (int i = 1; i <= 6; i++) begin stepClock(); map[i] = tick[2]; end
    nChecks++; if (map !== 32'h0) begin nFails++; $display("[TB] FAIL off_track_enable got=%h exp=%h", map, 32'h0); end
    level = 4'b0000; map = '0;
    for (int i = 1; i <= 6; i++) begin stepClock(); map[i] = tick[2]; end
    nChecks++; if (map !== 32'h0000_0008) begin nFails++; $display("[TB] FAIL off_track_fall got=%h exp=%h", map, 32'h0000_0008); end
    nChecks++; if (cnt(2) !== 8'd2) begin nFails++; $display("[TB] FAIL off_track_count got=%0d exp=%0d", cnt(2), 2); end
  endtask

  task automatic test_saturation();
    mode = 8'b1100_0000; dbLimit = 4'd0; level = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      level[3] = ~level[3];
      stepClock();
    end
    repeat (5) stepClock();
    nChecks++; if (cnt(3) !== 8'd255) begin nFails++; $display("[TB] FAIL sat_count got=%0d exp=%0d", cnt(3), 255); end
    nChecks++; if (flag[3] !== 1'b1) begin nFails++; $display("[TB] FAIL sat_flag got=%b exp=%b", flag[3], 1'b1); end
    level[3] = ~level[3];
    for (int i = 1; i <= 3; i++) begin
      stepClock();
      if (i == 2) clr = 4'b1000;
    end
    clr = 4'b0000;
    nChecks++; if (tick[3] !== 1'b1) begin nFails++; $display("[TB] FAIL clrtick_tick got=%b exp=%b", tick[3], 1'b1); end
    nChecks++; if (flag[3] !== 1'b1) begin nFails++; $display("[TB] FAIL clrtick_flag got=%b exp=%b", flag[3], 1'b1); end
    nChecks++; if (cnt(3) !== 8'd1) begin nFails++; $display("[TB] FAIL clrtick_count got=%0d exp=%0d", cnt(3), 1); end
    stepClock();
    clr = 4'b1000; stepClock(); clr = 4'b0000;
    nChecks++; if (cnt(3) !== 8'd0) begin nFails++; $display("[TB] FAIL clr_count got=%0d exp=%0d", cnt(3), 0); end
    nChecks++; if (flag[3] !== 1'b0) begin nFails++; $display("[TB] FAIL clr_flag got=%b exp=%b", flag[3], 1'b0); end
  endtask

  task automatic test_simultaneous();
    logic [CH-1:0] expFlag;
    mode = 8'b0101_0101; level = 4'b0000;
    repeat (6) stepClock();
    clr = 4'b1111; stepClock(); clr = 4'b0000;
    nChecks++; if (flag !== 4'b0000) begin nFails++; $display("[TB] FAIL sim_pre_flag got=%b exp=%b", flag, 4'b0000); end
    nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL sim_pre_irq got=%b exp=%b", irq, 1'b0); end
    level = 4'b1111;
    repeat (3) stepClock();
    nChecks++; if (tick !== 4'b1111) begin nFails++; $display("[TB] FAIL sim_tick got=%b exp=%b", tick, 4'b1111); end
    nChecks++; if (flag !== 4'b1111) begin nFails++; $display("[TB] FAIL sim_flag got=%b exp=%b", flag, 4'b1111); end
    nChecks++; if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL sim_irq got=%b exp=%b", irq, 1'b1); end
    stepClock();
    expFlag = 4'b1111;
    for (int ch = 0; ch < CH; ch++) begin
      clr = CH'(1 << ch); stepClock(); clr = 4'b0000;
      expFlag[ch] = 1'b0;
      nChecks++; if (flag !== expFlag) begin nFails++; $display("[TB] FAIL sim_clr%0d_flag got=%b exp=%b", ch, flag, expFlag); end
      nChecks++; if (irq !== (expFlag != 4'b0000)) begin nFails++; $display("[TB] FAIL sim_clr%0d_irq got=%b exp=%b", ch, irq, (expFlag != 4'b0000)); end
    end
  endtask

  task automatic test_reset_hold();
    logic [31:0] map;
    reset = 1'b1; level = 4'b0001; mode = 8'b0000_0001; dbLimit = 4'd0;
    repeat (3) stepClock();
    nChecks++; if (flag !== 4'b0000) begin nFails++; $display("[TB] FAIL hold_rst_flag got=%b exp=%b", flag, 4'b0000); end
    nChecks++; if (count !== 32'h0) begin nFails++; $display("[TB] FAIL hold_rst_count got=%h exp=%h", count, 32'h0); end
    reset = 1'b0; map = '0;
    for (int i = 1; i <= 6; i++) begin stepClock(); map[i] = tick[0]; end
    nChecks++; if (map !== 32'h0000_0008) begin nFails++; $display("[TB] FAIL hold_rise got=%h exp=%h", map, 32'h0000_0008); end
    nChecks++; if (flag !== 4'b0001) begin nFails++; $display("[TB] FAIL hold_flag got=%b exp=%b", flag, 4'b0001); end
    mode = 8'b0000_0011; dbLimit = 4'd5; level = 4'b0000;
    repeat (4) stepClock();
    #2 reset = 1'b1;
    #1;
    nChecks++; if (tick !== 4'b0000) begin nFails++; $display("[TB] FAIL abort_tick got=%b exp=%b", tick, 4'b0000); end
    nChecks++; if (flag !== 4'b0000) begin nFails++; $display("[TB] FAIL abort_flag got=%b exp=%b", flag, 4'b0000); end
    nChecks++; if (count !== 32'h0) begin nFails++; $display("[TB] FAIL abort_count got=%h exp=%h", count, 32'h0); end
    nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL abort_irq got=%b exp=%b", irq, 1'b0); end
    repeat (2) stepClock();
    reset = 1'b0; map = '0;
    for (int i = 1; i <= 20; i++) begin stepClock(); map[i] = tick[0]; end
    nChecks++; if (map !== 32'h0) begin nFails++; $display("[TB] FAIL abort_late_tick got=%h exp=%h", map, 32'h0); end
  endtask

  // Scenarios run back to back; each one leaves the channels it used in a known state.
  initial begin
    test_reset();
    test_latency();
    test_debounce();
    test_falling_and_off();
    test_saturation();
    test_simultaneous();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
